mm_stream_mac: RTL and testbench
================================

Name: mm_stream_mac

Overview:
- Parametrised successor to the team's matrix-multiply engine. Computes C = A x B for signed matrices of M x K and K x N held in external memory.
- Generalises data and accumulator widths. Replaces the free-running flow with a start/busy/finish handshake.
- Adds wait-state-tolerant read/write handshakes, size validation with an error flag, and optional saturating accumulation.
- Sits between the testbench or host memory model and the memory port. Same i/j/index addressing style as the existing engine.

Parameters:
- DW, 20, signed element width of A and B.
- AW, 20, width of the i/j address and size fields.
- ACCW, 48, signed accumulator and write_data width. Must be >= 2*DW.
- MAXDIM, 16, largest legal M, K or N.
- SAT, 0, 1 = saturate the accumulator at each add; 0 = two's-complement wrap.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a job. Sampled only in IDLE.
- i  out  AW  row address for reads and writes.
- j  out  AW  column address for reads and writes.
- sel  out  2  read target: 0 = size table, 1 = A, 2 = B.
- read  out  1  read request.
- read_valid  in  1  read_data valid; completes the read.
- read_data  in  DW  signed read data.
- write  out  1  write request for C[i][j].
- write_ready  in  1  write accepted.
- write_data  out  ACCW  signed C element.
- busy  out  1  high in every state except IDLE.
- finish  out  1  one-cycle pulse at job end.
- error  out  1  size error; held until the next accepted start.

Behaviour:
- Reset (reset=0, async): state=IDLE. i, j, sel, read, write, write_data, busy, finish, error, accumulator, and M/K/N registers all 0.
- States: IDLE, SIZE, CHECK, RD_A, RD_B, WRITE, DONE.
- IDLE: start=1 at an edge -> SIZE, and error clears. start while busy is ignored.
- SIZE: three reads with sel=0, i=0/1/2, j=0. Captures M, K, N from read_data[AW-1:0], read as unsigned. After the third accepted read -> CHECK.
- CHECK (1 cycle): if any of M, K, N is 0 or > MAXDIM -> error=1, -> DONE, no writes. Otherwise row=0, col=0, k=0, acc=0, -> RD_A.
- RD_A: sel=1, i=row, j=k. On accept, latch a -> RD_B.
- RD_B: sel=2, i=k, j=col. On accept: acc += a*read_data. The product is a full 2*DW signed value, sign-extended to ACCW.
  - SAT=1: clamp to [-2^(ACCW-1), 2^(ACCW-1)-1] at every add.
  - Then k==K-1 -> WRITE, else k++ -> RD_A.
- WRITE: write=1, i=row, j=col, write_data=acc. On write_ready=1:
  - acc=0, k=0.
  - col==N-1 ? (col=0, row++) : col++.
  - Last element (row==M-1 and col==N-1) -> DONE, else -> RD_A.
- DONE: finish=1 for exactly one cycle -> IDLE.
- Handshake rules:
  - A read completes in a cycle where read=1 and read_valid=1. Zero-latency memory (read_valid tied high) is legal.
  - While read or write is waiting, i, j, sel and write_data stay stable.
  - read and write are never high together. read=0 outside SIZE/RD_A/RD_B.
- Output order of C is row-major.
- Timing with zero-wait memory: finish is high in the cycle after edge 4+M*N*(2K+1), counting the start-sampling edge as edge 0.
- Reset mid-job: immediate return to IDLE. No finish pulse, partial results discarded.
- read_valid or write_ready asserted without a matching request: ignored.

Test Plan:
- 2x2x2 job, zero-wait memory. A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> writes 19, 22, 43, 50 at (0,0), (0,1), (1,0), (1,1). finish pulses in cycle 25 after start, error=0.
- Same job with read_valid delayed by 2 cycles per read and write_ready by 3 -> identical write sequence. i, j, sel and write_data stable while waiting; one finish pulse.
- Signed and non-square: M=1, K=3, N=1, A=[-2,3,-4], B=[5,-6,7] -> single write of -56.
- DW=8, ACCW=16, K=3, all A and B elements = -128:
  - SAT=1 -> write_data=32767.
  - SAT=0 -> write_data=-16384.
- Size error: K=0 -> error=1, finish pulse, no write. With MAXDIM=16 and N=17 -> same result. error clears on the next start.
- Assert reset=0 mid-RD_B -> all outputs 0 asynchronously. A new start then runs a 2x2x2 job to correct results. A start pulse during busy is ignored.

Source files
------------

// File: rtl/mm_stream_mac.sv
// ---------------------------------------------------------------------------
// mm_stream_mac : streaming C = A x B engine over a handshaked memory port
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module mm_stream_mac #(
  parameter int DW     = 20,
  parameter int AW     = 20,
  parameter int ACCW   = 48,
  parameter int MAXDIM = 16,
  parameter int SAT    = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic [AW-1:0]          i,
  output logic [AW-1:0]          j,
  output logic [1:0]             sel,
  output logic                   read,
  input  logic                   read_valid,
  input  logic signed [DW-1:0]   read_data,
  output logic                   write,
  input  logic                   write_ready,
  output logic signed [ACCW-1:0] write_data,
  output logic                   busy,
  output logic                   finish,
  output logic                   error
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SIZE  = 3'd1,
    S_CHECK = 3'd2,
    S_RD_A  = 3'd3,
    S_RD_B  = 3'd4,
    S_WRITE = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [AW-1:0] DIM_MAX = AW'(MAXDIM);
  localparam logic [AW-1:0] ONE     = AW'(1);
  localparam logic signed [ACCW-1:0] ACC_MAX = {1'b0, {(ACCW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] ACC_MIN = {1'b1, {(ACCW-1){1'b0}}};

  state_t                 state_q, state_d;
  logic [1:0]             idx_q, idx_d;
  logic [AW-1:0]          m_q, m_d, k_q, k_d, n_q, n_d;
  logic [AW-1:0]          row_q, row_d, col_q, col_d, kk_q, kk_d;
  logic signed [DW-1:0]   a_q, a_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic                   err_q, err_d;

  logic [DW-1:0]          rd_raw;
  logic [AW-1:0]          rd_size;
  logic signed [2*DW-1:0] prod;
  logic signed [ACCW-1:0] prod_ext;
  logic [ACCW:0]          sum;
  logic                   sum_ovf;
  logic signed [ACCW-1:0] acc_add;
  logic                   size_bad;

  // Sizes are unsigned, so view read_data without its sign before resizing.
  assign rd_raw   = read_data;
  assign rd_size  = AW'(rd_raw);
  assign prod     = a_q * read_data;
  assign prod_ext = ACCW'(prod);
  assign sum      = {acc_q[ACCW-1], acc_q} + {prod_ext[ACCW-1], prod_ext};
  assign sum_ovf  = sum[ACCW] ^ sum[ACCW-1];

  always_comb begin
    acc_add = sum[ACCW-1:0];
    if (SAT != 0 && sum_ovf) acc_add = sum[ACCW] ? ACC_MIN : ACC_MAX;
  end

  assign size_bad = (m_q == '0) || (m_q > DIM_MAX) || (k_q == '0) ||
                    (k_q > DIM_MAX) || (n_q == '0) || (n_q > DIM_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      m_q     <= '0;
      k_q     <= '0;
      n_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      kk_q    <= '0;
      a_q     <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      m_q     <= m_d;
      k_q     <= k_d;
      n_q     <= n_d;
      row_q   <= row_d;
      col_q   <= col_d;
      kk_q    <= kk_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    m_d     = m_q;
    k_d     = k_q;
    n_d     = n_q;
    row_d   = row_q;
    col_d   = col_q;
    kk_d    = kk_q;
    a_d     = a_q;
    acc_d   = acc_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SIZE;
          idx_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_SIZE: begin
        if (read_valid) begin
          case (idx_q)
            2'd0:    m_d = rd_size;
            2'd1:    k_d = rd_size;
            default: n_d = rd_size;
          endcase
          if (idx_q == 2'd2) state_d = S_CHECK;
          else               idx_d   = idx_q + 2'd1;
        end
      end
      S_CHECK: begin
        if (size_bad) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          row_d   = '0;
          col_d   = '0;
          kk_d    = '0;
          acc_d   = '0;
          state_d = S_RD_A;
        end
      end
      S_RD_A: begin
        if (read_valid) begin
          a_d     = read_data;
          state_d = S_RD_B;
        end
      end
      S_RD_B: begin
        if (read_valid) begin
          acc_d = acc_add;
          if (kk_q == k_q - ONE) begin
            state_d = S_WRITE;
          end else begin
            kk_d    = kk_q + ONE;
            state_d = S_RD_A;
          end
        end
      end
      S_WRITE: begin
        if (write_ready) begin
          acc_d = '0;
          kk_d  = '0;
          if (col_q == n_q - ONE) begin
            col_d = '0;
            row_d = row_q + ONE;
          end else begin
            col_d = col_q + ONE;
          end
          if (row_q == m_q - ONE && col_q == n_q - ONE) state_d = S_DONE;
          else                                          state_d = S_RD_A;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Address/select are pure functions of registered state, hence stable while waiting.
  always_comb begin
    i     = '0;
    j     = '0;
    sel   = 2'd0;
    read  = 1'b0;
    write = 1'b0;
    case (state_q)
      S_SIZE: begin
        read = 1'b1;
        i    = AW'(idx_q);
      end
      S_RD_A: begin
        read = 1'b1;
        sel  = 2'd1;
        i    = row_q;
        j    = kk_q;
      end
      S_RD_B: begin
        read = 1'b1;
        sel  = 2'd2;
        i    = kk_q;
        j    = col_q;
      end
      S_WRITE: begin
        write = 1'b1;
        i     = row_q;
        j     = col_q;
      end
      default: ;
    endcase
  end

  assign write_data = acc_q;
  assign busy       = (state_q != S_IDLE);
  assign finish     = (state_q == S_DONE);
  assign error      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mm_stream_mac.sv
// ---------------------------------------------------------------------------
// tb_mm_stream_mac : directed self-checking bench for mm_stream_mac
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mm_stream_mac;

  localparam int DW   = 20;
  localparam int AW   = 20;
  localparam int ACCW = 48;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic start_s = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0]          dut_i, dut_j;
  logic [1:0]             dut_sel;
  logic                   dut_read, dut_rvalid, dut_write, dut_wready;
  logic signed [DW-1:0]   dut_rdata;
  logic signed [ACCW-1:0] dut_wdata;
  logic                   dut_busy, dut_finish, dut_error;

  int sz[4];
  int A[4][4];
  int B[4][4];
  int rdly = 0, wdly = 0, rcnt = 0, wcnt = 0;

  mm_stream_mac #(.DW(DW), .AW(AW), .ACCW(ACCW), .MAXDIM(16), .SAT(0)) u_dut (
    .clk(clk), .reset(reset), .start(start),
    .i(dut_i), .j(dut_j), .sel(dut_sel), .read(dut_read),
    .read_valid(dut_rvalid), .read_data(dut_rdata),
    .write(dut_write), .write_ready(dut_wready), .write_data(dut_wdata),
    .busy(dut_busy), .finish(dut_finish), .error(dut_error)
  );

  always_comb begin
    case (dut_sel)
      2'd0:    dut_rdata = DW'(sz[dut_i[1:0]]);
      2'd1:    dut_rdata = DW'(A[dut_i[1:0]][dut_j[1:0]]);
      default: dut_rdata = DW'(B[dut_i[1:0]][dut_j[1:0]]);
    endcase
  end

  assign dut_rvalid = dut_read  && (rcnt >= rdly);
  assign dut_wready = dut_write && (wcnt >= wdly);

  always @(posedge clk) begin
    rcnt <= (dut_read  && !dut_rvalid) ? rcnt + 1 : 0;
    wcnt <= (dut_write && !dut_wready) ? wcnt + 1 : 0;
  end

  // Two narrow instances for the saturate / wrap corner (all elements -128, K=3).
  logic [7:0]         s1_i, s1_j, s0_i, s0_j;
  logic [1:0]         s1_sel, s0_sel;
  logic               s1_rd, s0_rd, s1_wr, s0_wr, s1_busy, s0_busy;
  logic               s1_fin, s0_fin, s1_err, s0_err;
  logic signed [7:0]  s1_rdata, s0_rdata;
  logic signed [15:0] s1_wd, s0_wd;

  assign s1_rdata = (s1_sel == 2'd0) ? ((s1_i == 8'd1) ? 8'sd3 : 8'sd1) : 8'h80;
  assign s0_rdata = (s0_sel == 2'd0) ? ((s0_i == 8'd1) ? 8'sd3 : 8'sd1) : 8'h80;

  mm_stream_mac #(.DW(8), .AW(8), .ACCW(16), .MAXDIM(16), .SAT(1)) u_sat (
    .clk(clk), .reset(reset), .start(start_s),
    .i(s1_i), .j(s1_j), .sel(s1_sel), .read(s1_rd),
    .read_valid(1'b1), .read_data(s1_rdata),
    .write(s1_wr), .write_ready(1'b1), .write_data(s1_wd),
    .busy(s1_busy), .finish(s1_fin), .error(s1_err)
  );

  mm_stream_mac #(.DW(8), .AW(8), .ACCW(16), .MAXDIM(16), .SAT(0)) u_wrap (
    .clk(clk), .reset(reset), .start(start_s),
    .i(s0_i), .j(s0_j), .sel(s0_sel), .read(s0_rd),
    .read_valid(1'b1), .read_data(s0_rdata),
    .write(s0_wr), .write_ready(1'b1), .write_data(s0_wd),
    .busy(s0_busy), .finish(s0_fin), .error(s0_err)
  );

  int checks = 0, failures = 0;
  int cyc = 0, st_cyc = 0, fin_cyc = 0, fin_cnt = 0;
  int stab_err = 0, both_err = 0;
  int s1_n = 0, s0_n = 0, s1_f = 0, s0_f = 0;
  longint s1_v = 0, s0_v = 0;
  logic err_at_start = 1'b0, busy_at_start = 1'b0;
  longint wq_d[$];
  int wq_i[$], wq_j[$];
  logic [AW-1:0] si, sj;
  logic [1:0] ssel;
  logic signed [ACCW-1:0] swd;
  bit rwait = 1'b0, wwait = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      if (dut_read && dut_write) both_err++;
      if (rwait && (!dut_read || dut_i !== si || dut_j !== sj || dut_sel !== ssel)) stab_err++;
      if (wwait && (!dut_write || dut_i !== si || dut_j !== sj || dut_wdata !== swd)) stab_err++;
      rwait = dut_read && !dut_rvalid;
      wwait = dut_write && !dut_wready;
      si = dut_i; sj = dut_j; ssel = dut_sel; swd = dut_wdata;
      if (dut_write && dut_wready) begin
        wq_d.push_back(longint'(dut_wdata));
        wq_i.push_back(int'(dut_i));
        wq_j.push_back(int'(dut_j));
      end
      if (dut_finish) begin
        fin_cnt++;
        fin_cyc = cyc;
      end
      if (s1_wr) begin s1_n++; s1_v = longint'(s1_wd); end
      if (s0_wr) begin s0_n++; s0_v = longint'(s0_wd); end
      if (s1_fin) s1_f++;
      if (s0_fin) s0_f++;
    end else begin
      rwait = 1'b0;
      wwait = 1'b0;
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic init_2x2();
    sz[0] = 2; sz[1] = 2; sz[2] = 2; sz[3] = 0;
    A[0][0] = 1; A[0][1] = 2; A[1][0] = 3; A[1][1] = 4;
    B[0][0] = 5; B[0][1] = 6; B[1][0] = 7; B[1][1] = 8;
  endtask

  task automatic run_job(input int pulse_at);
    wq_d.delete(); wq_i.delete(); wq_j.delete();
    fin_cnt = 0;
    @(negedge clk); start = 1'b1; st_cyc = cyc;
    @(negedge clk); start = 1'b0;
    err_at_start  = dut_error;
    busy_at_start = dut_busy;
    for (int n = 0; n < 3000 && fin_cnt == 0; n++) begin
      @(negedge clk);
      start = (n == pulse_at) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_2x2(input string tag);
    longint ev[4] = '{19, 22, 43, 50};
    chk({tag, "_nwrites"}, wq_d.size(), 4);
    chk({tag, "_finish_pulses"}, fin_cnt, 1);
    chk({tag, "_error"}, dut_error, 0);
    for (int n = 0; n < 4 && n < wq_d.size(); n++) begin
      chk({tag, "_data"}, wq_d[n], ev[n]);
      chk({tag, "_row"}, wq_i[n], n / 2);
      chk({tag, "_col"}, wq_j[n], n % 2);
    end
  endtask

  initial begin
    init_2x2();
    repeat (3) @(negedge clk);
    chk("rst_busy", dut_busy, 0);
    chk("rst_finish", dut_finish, 0);
    chk("rst_error", dut_error, 0);
    chk("rst_rw", {dut_read, dut_write}, 0);
    chk("rst_addr", {dut_i, dut_j, dut_sel}, 0);
    chk("rst_wdata", dut_wdata, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 2x2x2 zero-wait: finish 25 cycles after the start cycle
    run_job(-1);
    check_2x2("zw");
    chk("zw_latency", fin_cyc - st_cyc, 25);
    chk("zw_busy_at_start", busy_at_start, 1);

    // Same job with wait states and a start pulse while busy
    rdly = 2; wdly = 3;
    run_job(10);
    check_2x2("ws");
    chk("ws_idle_after", dut_busy, 0);
    chk("ws_stable", stab_err, 0);
    chk("ws_rw_exclusive", both_err, 0);

    // Signed, non-square 1x3 * 3x1
    rdly = 1; wdly = 0;
    sz[0] = 1; sz[1] = 3; sz[2] = 1;
    A[0][0] = -2; A[0][1] = 3; A[0][2] = -4;
    B[0][0] = 5;  B[1][0] = -6; B[2][0] = 7;
    run_job(-1);
    chk("sg_nwrites", wq_d.size(), 1);
    chk("sg_data", (wq_d.size() > 0) ? wq_d[0] : 0, -56);
    chk("sg_error", dut_error, 0);

    // Size errors: K=0 and N=17
    rdly = 0;
    sz[0] = 2; sz[1] = 0; sz[2] = 2;
    run_job(-1);
    chk("k0_nwrites", wq_d.size(), 0);
    chk("k0_finish", fin_cnt, 1);
    chk("k0_error", dut_error, 1);
    sz[0] = 2; sz[1] = 2; sz[2] = 17;
    run_job(-1);
    chk("n17_nwrites", wq_d.size(), 0);
    chk("n17_finish", fin_cnt, 1);
    chk("n17_error", dut_error, 1);

    // Next start clears error
    init_2x2();
    run_job(-1);
    chk("clr_err_at_start", err_at_start, 0);
    check_2x2("clr");

    // Asynchronous reset in the middle of RD_B
    rdly = 2; wdly = 1;
    wq_d.delete(); wq_i.delete(); wq_j.delete();
    fin_cnt = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int n = 0; n < 200 && !(dut_read && dut_sel == 2'd2); n++) @(negedge clk);
    chk("ar_reached_rdb", dut_sel, 2);
    #2 reset = 1'b0;
    #1;
    chk("ar_busy", dut_busy, 0);
    chk("ar_rw", {dut_read, dut_write}, 0);
    chk("ar_addr", {dut_i, dut_j, dut_sel}, 0);
    chk("ar_wdata", dut_wdata, 0);
    chk("ar_flags", {dut_finish, dut_error}, 0);
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("ar_no_finish", fin_cnt, 0);
    chk("ar_no_write", wq_d.size(), 0);
    run_job(-1);
    check_2x2("ar_rerun");

    // Narrow instances: saturate vs wrap
    @(negedge clk); start_s = 1'b1;
    @(negedge clk); start_s = 1'b0;
    for (int n = 0; n < 100 && (s1_f == 0 || s0_f == 0); n++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("sat_nwrites", s1_n, 1);
    chk("sat_data", s1_v, 32767);
    chk("wrap_nwrites", s0_n, 1);
    chk("wrap_data", s0_v, -16384);
    chk("narrow_err", {s1_err, s0_err}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
